// File: rtl/iopad_ctrl_pkg.sv
// iopad_ctrl_pkg: shared encodings for the iopad bank direction controller.
package iopad_ctrl_pkg;
  typedef enum logic [2:0] {IDLE, TURN_OUT, DRIVE, TURN_IN, SAMPLE} state_e;
  typedef enum logic {WR = 1'b0, RD = 1'b1} grant_e;
  localparam logic PAD_EN_INPUT  = 1'b1;
  localparam logic PAD_EN_OUTPUT = 1'b0;
  localparam int   CNT_W         = 4;
endpackage

// File: rtl/iopad_rr_arb2.sv
// iopad_rr_arb2: two-requester round-robin arbiter; on a tie, the requester not granted last time wins.
module iopad_rr_arb2
  import iopad_ctrl_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic wr_req_i,
  input  logic rd_req_i,
  input  logic upd_i,
  output logic gnt_wr_o,
  output logic gnt_rd_o
);
  grant_e last_q, last_d;
  always_comb begin
    gnt_wr_o = wr_req_i & (~rd_req_i | (last_q == RD));
    gnt_rd_o = rd_req_i & ~gnt_wr_o;
    last_d   = (upd_i & gnt_wr_o) ? WR : (upd_i & gnt_rd_o) ? RD : last_q;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) last_q <= RD;
    else     last_q <= last_d;
endmodule

// File: rtl/iopad_bank_dir_ctrl.sv
// iopad_bank_dir_ctrl: shared-direction iopad bank sequencer with turnaround dead cycles
// between driving written words and sampling the pads for reads.
module iopad_bank_dir_ctrl
  import iopad_ctrl_pkg::*;
#(
  parameter int NUM_PADS    = 8,
  parameter int TURN_CYCLES = 2,
  parameter int HOLD_CYCLES = 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                wr_valid_i,
  input  logic [NUM_PADS-1:0] wr_data_i,
  output logic                wr_ready_o,
  input  logic                rd_req_i,
  output logic                rd_valid_o,
  output logic [NUM_PADS-1:0] rd_data_o,
  output logic [NUM_PADS-1:0] pad_out_o,
  output logic [NUM_PADS-1:0] pad_en_o,
  input  logic [NUM_PADS-1:0] pad_in_i,
  output logic                busy_o
);
  if (TURN_CYCLES < 1 || TURN_CYCLES > 15 || HOLD_CYCLES < 1 || HOLD_CYCLES > 15) begin : g_bad_param
    $error("iopad_bank_dir_ctrl: TURN_CYCLES and HOLD_CYCLES must be within 1..15");
  end
  localparam logic [CNT_W-1:0] TURN_LD = CNT_W'(TURN_CYCLES - 1);
  localparam logic [CNT_W-1:0] HOLD_LD = CNT_W'(HOLD_CYCLES - 1);
  state_e              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [NUM_PADS-1:0] data_q, data_d, pad_out_q, pad_out_d, rd_data_q, rd_data_d;
  logic                pad_en_q, pad_en_d, rd_valid_q, rd_valid_d;
  logic                rd_req_m, gnt_wr, gnt_rd, cnt_zero, stream;
  // the requester holds rd_req until it sees rd_valid, so that cycle must not re-grant
  assign rd_req_m = rd_req_i & ~rd_valid_q;
  assign cnt_zero = cnt_q == '0;
  assign stream   = (state_q == DRIVE) && cnt_zero && wr_valid_i && !rd_req_m;
  iopad_rr_arb2 u_arb (
    .clk      (clk),
    .rst      (rst),
    .wr_req_i (wr_valid_i),
    .rd_req_i (rd_req_m),
    .upd_i    (state_q == IDLE),
    .gnt_wr_o (gnt_wr),
    .gnt_rd_o (gnt_rd)
  );
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      data_q     <= '0;
      pad_out_q  <= '0;
      pad_en_q   <= PAD_EN_INPUT;
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      data_q     <= data_d;
      pad_out_q  <= pad_out_d;
      pad_en_q   <= pad_en_d;
      rd_data_q  <= rd_data_d;
      rd_valid_q <= rd_valid_d;
    end
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_zero ? cnt_q : cnt_q - 1'b1;
    case (state_q)
      IDLE:     if (gnt_wr) begin state_d = TURN_OUT; cnt_d = TURN_LD; end
                else if (gnt_rd) state_d = SAMPLE;
      TURN_OUT: if (cnt_zero) begin state_d = DRIVE; cnt_d = HOLD_LD; end
      DRIVE:    if (cnt_zero) begin state_d = stream ? DRIVE : TURN_IN; cnt_d = stream ? HOLD_LD : TURN_LD; end
      TURN_IN:  if (cnt_zero) state_d = IDLE;
      default:  state_d = IDLE;
    endcase
  end
  // pad registers follow the next state so the direction flips exactly on DRIVE entry/exit
  always_comb begin
    wr_ready_o = ((state_q == IDLE) && gnt_wr) || stream;
    data_d     = wr_ready_o ? wr_data_i : data_q;
    pad_en_d   = (state_d == DRIVE) ? PAD_EN_OUTPUT : PAD_EN_INPUT;
    pad_out_d  = (state_d == DRIVE) ? data_d : pad_out_q;
    rd_valid_d = state_q == SAMPLE;
    rd_data_d  = (state_q == SAMPLE) ? pad_in_i : rd_data_q;
  end
  assign pad_en_o   = {NUM_PADS{pad_en_q}};
  assign pad_out_o  = pad_out_q;
  assign rd_data_o  = rd_data_q;
  assign rd_valid_o = rd_valid_q;
  assign busy_o     = state_q != IDLE;
endmodule
